// File: rtl/packet_demux_pkg.sv
// Shared definitions for the packet demultiplexer: default stream widths,
// the completed-packet counter width and the routing FSM state encoding.
package packet_demux_pkg;

    localparam int unsigned DefDataWidth  = 256;
    localparam int unsigned DefTuserWidth = 128;
    localparam int unsigned DefSelBit     = 24;
    localparam int unsigned CntWidth      = 32;

    // IDLE = 0, PKT0 = 1, PKT1 = 2
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPkt0 = 2'd1,
        StPkt1 = 2'd2
    } demux_state_e;

    // Locked-route state entered after the first beat of a multi-beat packet.
    function automatic demux_state_e first_beat_state(input logic sel1);
        return sel1 ? StPkt1 : StPkt0;
    endfunction

endpackage

// File: rtl/pkt_counter.sv
// Free-running completed-packet counter with enable and asynchronous clear.
// Wraps from all-ones back to zero.
module pkt_counter
    import packet_demux_pkg::*;
#(
    parameter int unsigned Width = CntWidth
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q;

    // Count enabled events; the clear wins and acts immediately.
    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/packet_demux.sv
// One-to-two AXI-Stream packet demultiplexer.
// The first beat of each packet picks the output from s_axis_tuser[SEL_BIT];
// the remaining beats follow the same output regardless of tuser. Data,
// strobe, user and last pass through combinationally; only tvalid/tready are
// steered.
// Build option: define PACKET_DEMUX_COUNTERS_EN to implement pkt_cnt_0/1;
// otherwise both counts read as zero and no counter flops exist.
module packet_demux
    import packet_demux_pkg::*;
#(
    parameter int unsigned C_AXIS_DATA_WIDTH  = DefDataWidth,
    parameter int unsigned C_AXIS_TUSER_WIDTH = DefTuserWidth,
    parameter int unsigned SEL_BIT            = DefSelBit
) (
    input  logic                            axi_aclk,
    input  logic                            axi_reset,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,

    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_0,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_0,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_0,
    output logic                            m_axis_tvalid_0,
    output logic                            m_axis_tlast_0,
    input  logic                            m_axis_tready_0,

    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_1,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_1,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_1,
    output logic                            m_axis_tvalid_1,
    output logic                            m_axis_tlast_1,
    input  logic                            m_axis_tready_1,

    output logic [CntWidth-1:0]             pkt_cnt_0,
    output logic [CntWidth-1:0]             pkt_cnt_1
);

    demux_state_e state_q;
    logic         route1;
    logic         hs;

    // Current route: live tuser bit on a first beat, locked while mid-packet.
    always_comb begin
        route1 = 1'b0;
        unique case (state_q)
            StIdle:  route1 = s_axis_tuser[SEL_BIT];
            StPkt0:  route1 = 1'b0;
            StPkt1:  route1 = 1'b1;
            default: route1 = 1'b0;
        endcase
    end

    // Payload is shared by both outputs; only valid/ready are steered.
    // Reset gates valid and ready so nothing transfers while it is held.
    always_comb begin
        m_axis_tdata_0  = s_axis_tdata;
        m_axis_tstrb_0  = s_axis_tstrb;
        m_axis_tuser_0  = s_axis_tuser;
        m_axis_tlast_0  = s_axis_tlast;
        m_axis_tdata_1  = s_axis_tdata;
        m_axis_tstrb_1  = s_axis_tstrb;
        m_axis_tuser_1  = s_axis_tuser;
        m_axis_tlast_1  = s_axis_tlast;
        m_axis_tvalid_0 = ~axi_reset & s_axis_tvalid & ~route1;
        m_axis_tvalid_1 = ~axi_reset & s_axis_tvalid & route1;
        s_axis_tready   = ~axi_reset & (route1 ? m_axis_tready_1 : m_axis_tready_0);
    end

    assign hs = s_axis_tvalid & s_axis_tready;

    // Routing FSM: lock on a non-last first beat, release on the last beat.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state_q <= StIdle;
        end else if (hs) begin
            if (s_axis_tlast) begin
                state_q <= StIdle;
            end else if (state_q == StIdle) begin
                state_q <= first_beat_state(route1);
            end
        end
    end

`ifdef PACKET_DEMUX_COUNTERS_EN
    logic inc_0;
    logic inc_1;

    // A last-beat handshake goes to exactly one output, so at most one
    // counter advances per cycle.
    always_comb begin
        inc_0 = hs & s_axis_tlast & ~route1;
        inc_1 = hs & s_axis_tlast & route1;
    end

    pkt_counter #(
        .Width (CntWidth)
    ) u_cnt0 (
        .clk_i (axi_aclk),
        .clr_i (axi_reset),
        .en_i  (inc_0),
        .cnt_o (pkt_cnt_0)
    );

    pkt_counter #(
        .Width (CntWidth)
    ) u_cnt1 (
        .clk_i (axi_aclk),
        .clr_i (axi_reset),
        .en_i  (inc_1),
        .cnt_o (pkt_cnt_1)
    );
`else
    assign pkt_cnt_0 = '0;
    assign pkt_cnt_1 = '0;
`endif

endmodule

// File: tb/tb_packet_demux.sv
// Directed bench for packet_demux with default parameters (256/128, bit 24).
// Counter expectations collapse to zero when PACKET_DEMUX_COUNTERS_EN is not
// defined.
module tb_packet_demux;

    logic         clk;
    logic         rst;
    logic [255:0] s_tdata;
    logic [31:0]  s_tstrb;
    logic [127:0] s_tuser;
    logic         s_tvalid;
    logic         s_tlast;
    logic         s_tready;
    logic [255:0] m_tdata_0, m_tdata_1;
    logic [31:0]  m_tstrb_0, m_tstrb_1;
    logic [127:0] m_tuser_0, m_tuser_1;
    logic         m_tvalid_0, m_tvalid_1;
    logic         m_tlast_0, m_tlast_1;
    logic         m_tready_0, m_tready_1;
    logic [31:0]  cnt_0, cnt_1;

    int n_total = 0;
    int n_bad   = 0;
    int beats_0 = 0;
    int beats_1 = 0;

    packet_demux dut (
        .axi_aclk        (clk),
        .axi_reset       (rst),
        .s_axis_tdata    (s_tdata),
        .s_axis_tstrb    (s_tstrb),
        .s_axis_tuser    (s_tuser),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tlast    (s_tlast),
        .s_axis_tready   (s_tready),
        .m_axis_tdata_0  (m_tdata_0),
        .m_axis_tstrb_0  (m_tstrb_0),
        .m_axis_tuser_0  (m_tuser_0),
        .m_axis_tvalid_0 (m_tvalid_0),
        .m_axis_tlast_0  (m_tlast_0),
        .m_axis_tready_0 (m_tready_0),
        .m_axis_tdata_1  (m_tdata_1),
        .m_axis_tstrb_1  (m_tstrb_1),
        .m_axis_tuser_1  (m_tuser_1),
        .m_axis_tvalid_1 (m_tvalid_1),
        .m_axis_tlast_1  (m_tlast_1),
        .m_axis_tready_1 (m_tready_1),
        .pkt_cnt_0       (cnt_0),
        .pkt_cnt_1       (cnt_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Expected counter value given the build option.
    function automatic logic [31:0] ce(input logic [31:0] v);
`ifdef PACKET_DEMUX_COUNTERS_EN
        return v;
`else
        return (v & 32'h0);
`endif
    endfunction

    // Present one beat from the negedge, check routing before the next posedge.
    task automatic beat(input string tag, input logic [255:0] d, input logic sel,
                        input logic last, input logic r0, input logic r1,
                        input int exp_port);
        logic [127:0] u;
        u = d[127:0];
        u[24] = sel;
        @(negedge clk);
        s_tdata    = d;
        s_tstrb    = d[31:0];
        s_tuser    = u;
        s_tlast    = last;
        s_tvalid   = 1'b1;
        m_tready_0 = r0;
        m_tready_1 = r1;
        #1;
        check({tag, ".v0"}, {255'd0, m_tvalid_0}, {255'd0, exp_port == 0});
        check({tag, ".v1"}, {255'd0, m_tvalid_1}, {255'd0, exp_port == 1});
        check({tag, ".rdy"}, {255'd0, s_tready}, {255'd0, (exp_port == 0) ? r0 : r1});
        if (exp_port == 0) begin
            check({tag, ".d0"}, m_tdata_0, d);
            check({tag, ".u0"}, {128'd0, m_tuser_0}, {128'd0, u});
            check({tag, ".l0"}, {255'd0, m_tlast_0}, {255'd0, last});
        end else begin
            check({tag, ".d1"}, m_tdata_1, d);
            check({tag, ".s1"}, {224'd0, m_tstrb_1}, {224'd0, d[31:0]});
            check({tag, ".l1"}, {255'd0, m_tlast_1}, {255'd0, last});
        end
        if (m_tvalid_0 && m_tready_0) beats_0++;
        if (m_tvalid_1 && m_tready_1) beats_1++;
    endtask

    task automatic idle();
        @(negedge clk);
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        m_tready_0 = 1'b1;
        m_tready_1 = 1'b1;
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        s_tdata    = '0;
        s_tstrb    = '0;
        s_tuser    = '0;
        s_tvalid   = 1'b1;
        s_tlast    = 1'b0;
        m_tready_0 = 1'b1;
        m_tready_1 = 1'b1;

        // Reset: outputs gated, counters clear.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.v0", {255'd0, m_tvalid_0}, 256'd0);
        check("rst.v1", {255'd0, m_tvalid_1}, 256'd0);
        check("rst.rdy", {255'd0, s_tready}, 256'd0);
        check("rst.c0", {224'd0, cnt_0}, 256'd0);
        check("rst.c1", {224'd0, cnt_1}, 256'd0);
        rst      = 1'b0;
        s_tvalid = 1'b0;

        // Three-beat packet to output 0.
        beat("p3.b0", {8{32'h0A00_0001}}, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        beat("p3.b1", {8{32'h0A00_0002}}, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        beat("p3.b2", {8{32'h0A00_0003}}, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        idle();
        check("p3.c0", {224'd0, cnt_0}, {224'd0, ce(32'd1)});
        check("p3.c1", {224'd0, cnt_1}, {224'd0, ce(32'd0)});

        // Single beat to 1, then back-to-back two-beat packet to 0.
        beat("sb.b0", {8{32'h0B00_0001}}, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        beat("p2.b0", {8{32'h0B00_0002}}, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        beat("p2.b1", {8{32'h0B00_0003}}, 1'b1, 1'b1, 1'b1, 1'b1, 0);
        idle();
        check("p2.c0", {224'd0, cnt_0}, {224'd0, ce(32'd2)});
        check("p2.c1", {224'd0, cnt_1}, {224'd0, ce(32'd1)});

        // Four beats to output 1 with the select bit toggling after the first.
        beat("p4.b0", {8{32'h0C00_0001}}, 1'b1, 1'b0, 1'b1, 1'b1, 1);
        beat("p4.b1", {8{32'h0C00_0002}}, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        beat("p4.b2", {8{32'h0C00_0003}}, 1'b1, 1'b0, 1'b1, 1'b1, 1);
        beat("p4.b3", {8{32'h0C00_0004}}, 1'b0, 1'b1, 1'b1, 1'b1, 1);
        idle();
        check("p4.c1", {224'd0, cnt_1}, {224'd0, ce(32'd2)});

        // Output 0 stalls for five cycles mid-packet; output 1 readiness ignored.
        beats_0 = 0;
        beats_1 = 0;
        beat("st.b0", {8{32'h0D00_0001}}, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            beat("st.hold", {8{32'h0D00_0002}}, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        end
        beat("st.b1", {8{32'h0D00_0002}}, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        beat("st.b2", {8{32'h0D00_0003}}, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        idle();
        check("st.beats0", 256'(beats_0), 256'd3);
        check("st.beats1", 256'(beats_1), 256'd0);
        check("st.c0", {224'd0, cnt_0}, {224'd0, ce(32'd3)});

        // Output 1 not ready does not block a packet to output 0.
        beat("nb.b0", {8{32'h0E00_0001}}, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        idle();
        check("nb.c0", {224'd0, cnt_0}, {224'd0, ce(32'd4)});

`ifdef PACKET_DEMUX_COUNTERS_EN
        // Wrap of a preloaded counter.
        @(negedge clk);
        force dut.u_cnt0.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_cnt0.cnt_q;
        beat("wr.b0", {8{32'h0F00_0001}}, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        idle();
        check("wr.c0", {224'd0, cnt_0}, 256'd0);
`endif

        // Reset after beat 2 of a four-beat packet to output 1.
        beat("ra.b0", {8{32'h1000_0001}}, 1'b1, 1'b0, 1'b1, 1'b1, 1);
        beat("ra.b1", {8{32'h1000_0002}}, 1'b1, 1'b0, 1'b1, 1'b1, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ra.v0", {255'd0, m_tvalid_0}, 256'd0);
        check("ra.v1", {255'd0, m_tvalid_1}, 256'd0);
        check("ra.rdy", {255'd0, s_tready}, 256'd0);
        check("ra.c0", {224'd0, cnt_0}, 256'd0);
        check("ra.c1", {224'd0, cnt_1}, 256'd0);
        @(negedge clk);
        rst      = 1'b0;
        s_tvalid = 1'b0;
        beat("ra.n0", {8{32'h1000_0003}}, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        beat("ra.n1", {8{32'h1000_0004}}, 1'b1, 1'b1, 1'b1, 1'b1, 0);
        idle();
        check("ra.c0n", {224'd0, cnt_0}, {224'd0, ce(32'd1)});
        check("ra.c1n", {224'd0, cnt_1}, 256'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
